vga_timing_gen: RTL

Parametrised VGA timing generator: the next generation of the fixed 800x600 timing source feeding `draw_bg` in the VGA top. It produces the horizontal/vertical counters, sync and blanking for any resolution, with programmable sync polarity. It also provides a pixel-clock prescaler, an end-of-frame strobe and a frame counter for frame-rate logic such as `spawn`. Instantiated in `top_vga` in place of the current timing block; its outputs fill a `vga_if` bundle.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_axis_ctr.sv | 85 ++++++++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - vga_mode_t   : one complete set of horizontal/vertical timing numbers
//   - MODE_*       : named standard resolutions
//   - axis_total() : line/frame length from the four per-axis parameters
//   - h_total() / v_total() : the same, applied to a vga_mode_t
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic hs_pol;
        logic vs_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        hs_pol: 1'b1, vs_pol: 1'b1
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    localparam vga_mode_t MODE_1024X768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29,
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input vga_mode_t m);
        return axis_total(m.h_active, m.h_fp, m.h_sync, m.h_bp);
    endfunction

    function automatic int v_total(input vga_mode_t m);
        return axis_total(m.v_active, m.v_fp, m.v_sync, m.v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// -----------------------------------------------------------------------------
// vga_axis_ctr
// One timing axis: a 0..TOTAL-1 counter with its blank and sync decode.
// Used once for the horizontal axis and once for the vertical axis.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active low
//   i_inc   in   advance the counter this cycle
//   o_cnt   out  current position, 0..TOTAL-1 (registered)
//   o_sync  out  sync at polarity POL, aligned to o_cnt (registered)
//   o_blnk  out  high while o_cnt >= ACTIVE, aligned to o_cnt (registered)
//   o_wrap  out  combinational: this cycle's increment takes the counter
//                from TOTAL-1 back to 0
// -----------------------------------------------------------------------------
module vga_axis_ctr
    import vga_pkg::*;
#(
    parameter int   ACTIVE = 800,
    parameter int   FP     = 40,
    parameter int   SYNC   = 128,
    parameter int   BP     = 88,
    parameter logic POL    = 1'b1,
    parameter int   CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sync,
    output logic             o_blnk,
    output logic             o_wrap
);

    localparam int               TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    // Thresholds kept 32 bits wide so a sync pulse ending exactly at
    // 2^CNT_W (zero back porch, full-range counter) cannot alias to 0.
    localparam logic [31:0]      BLNK_BEG = 32'(ACTIVE);
    localparam logic [31:0]      SYNC_BEG = 32'(ACTIVE + FP);
    localparam logic [31:0]      SYNC_END = 32'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sync;
    logic             r_blnk;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_at_last;
    logic             w_sync_act;

    assign w_at_last = (r_cnt == LAST);
    assign o_wrap    = i_inc & w_at_last;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_next_cnt = r_cnt;
        if (i_inc) begin
            w_next_cnt = w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Decode looks at the next count so sync/blank flip on the same edge as
    // the counter value they describe.
    assign w_sync_act = (32'(w_next_cnt) >= SYNC_BEG) &&
                        (32'(w_next_cnt) <  SYNC_END);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_blnk <= 1'b0;
            r_sync <= ~POL;
        end else begin
            r_cnt  <= w_next_cnt;
            r_blnk <= (32'(w_next_cnt) >= BLNK_BEG);
            r_sync <= w_sync_act ? POL : ~POL;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_sync = r_sync;
    assign o_blnk = r_blnk;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing source: pixel-clock prescaler, horizontal and
// vertical counters with sync/blank decode, end-of-frame strobe and a
// completed-frame counter. All outputs come straight from flops.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active low
//   pix_en     out  one-clk pixel tick, every CLK_DIV cycles
//   hcount     out  pixel column, 0..H_TOTAL-1
//   vcount     out  line, 0..V_TOTAL-1
//   hsync      out  horizontal sync, active level HS_POL
//   vsync      out  vertical sync, active level VS_POL
//   hblnk      out  horizontal blanking, active high
//   vblnk      out  vertical blanking, active high
//   frame_end  out  one-clk strobe in the cycle (0,0) follows a frame wrap
//   frame_cnt  out  completed frames, modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = MODE_800X600_60.h_active,
    parameter int   H_FP     = MODE_800X600_60.h_fp,
    parameter int   H_SYNC   = MODE_800X600_60.h_sync,
    parameter int   H_BP     = MODE_800X600_60.h_bp,
    parameter int   V_ACTIVE = MODE_800X600_60.v_active,
    parameter int   V_FP     = MODE_800X600_60.v_fp,
    parameter int   V_SYNC   = MODE_800X600_60.v_sync,
    parameter int   V_BP     = MODE_800X600_60.v_bp,
    parameter logic HS_POL   = MODE_800X600_60.hs_pol,
    parameter logic VS_POL   = MODE_800X600_60.vs_pol,
    parameter int   CLK_DIV  = 1,
    parameter int   CNT_W    = 11,
    parameter int   FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pix_en,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int     H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam longint CNT_RANGE = longint'(1) << CNT_W;
    localparam int     DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Parameter sanity, caught at elaboration.
    if (longint'(H_TOTAL) > CNT_RANGE) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL %0d does not fit CNT_W=%0d", H_TOTAL, CNT_W);
    end
    if (longint'(V_TOTAL) > CNT_RANGE) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL %0d does not fit CNT_W=%0d", V_TOTAL, CNT_W);
    end
    if (CLK_DIV < 1) begin : g_chk_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_chk_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end

    logic [DIV_W-1:0]   r_div;
    logic               r_pix_en;
    logic               r_frame_end;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_inc;

    // Prescaler. pix_en is registered from "prescaler at its last count", so
    // the first tick lands in the CLK_DIV-th cycle after reset releases and
    // the counters move on the edge that closes that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            r_pix_en <= (r_div == DIV_LAST);
        end
    end

    vga_axis_ctr #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .CNT_W  (CNT_W)
    ) u_h_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (r_pix_en),
        .o_cnt  (hcount),
        .o_sync (hsync),
        .o_blnk (hblnk),
        .o_wrap (w_h_wrap)
    );

    assign w_v_inc = r_pix_en & w_h_wrap;

    vga_axis_ctr #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .CNT_W  (CNT_W)
    ) u_v_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_v_inc),
        .o_cnt  (vcount),
        .o_sync (vsync),
        .o_blnk (vblnk),
        .o_wrap (w_v_wrap)
    );

    // A frame wrap is the vertical wrap (which already implies the horizontal
    // wrap on a pix_en cycle). Registering it puts frame_end in the same cycle
    // as the (0,0) it announces; reset never produces one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_end <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_end <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign pix_en    = r_pix_en;
    assign frame_end = r_frame_end;
    assign frame_cnt = r_frame_cnt;

endmodule
